// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   BUS_W          data-bus width in bits
//   F3_*           RV32I load/store width codes (funct3)
//   lsu_state_t    access sequencer state
package lsu_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for the load/store unit.
//   isLoad, isStore  op kind (mutually exclusive)
//   funct3           RV32I width code
//   offset           byte offset within the word (addr[1:0])
//   storeData        rs2 value, data in the low bits
//   rdata            word returned by the bus
//   illegal          misaligned access or unsupported funct3
//   wmask, wdata     byte enables and lane-replicated store data (0 for loads)
//   loadData         selected and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic             isLoad,
    input  logic             isStore,
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [BUS_W-1:0] storeData,
    input  logic [BUS_W-1:0] rdata,
    output logic             illegal,
    output logic [3:0]       wmask,
    output logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel  = rdata[{offset, 3'b000} +: 8];
        halfSel  = offset[1] ? rdata[31:16] : rdata[15:0];
        illegal  = 1'b0;
        wmask    = 4'b0000;
        wdata    = '0;
        loadData = '0;

        if (isLoad) begin
            case (funct3)
                F3_B:  loadData = {{24{byteSel[7]}}, byteSel};
                F3_BU: loadData = {24'd0, byteSel};
                F3_H: begin
                    illegal  = offset[0];
                    loadData = {{16{halfSel[15]}}, halfSel};
                end
                F3_HU: begin
                    illegal  = offset[0];
                    loadData = {16'd0, halfSel};
                end
                F3_W: begin
                    illegal  = |offset;
                    loadData = rdata;
                end
                default: illegal = 1'b1;
            endcase
        end else if (isStore) begin
            case (funct3)
                F3_B: begin
                    wmask = 4'b0001 << offset;
                    wdata = {4{storeData[7:0]}};
                end
                F3_H: begin
                    illegal = offset[0];
                    wmask   = 4'b0011 << {offset[1], 1'b0};
                    wdata   = {2{storeData[15:0]}};
                end
                F3_W: begin
                    illegal = |offset;
                    wmask   = 4'b1111;
                    wdata   = storeData;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns an EX/MEM load/store into a handshaked
// bus access, stalls the pipeline while it is outstanding, and abandons
// accesses that exceed TIMEOUT_CYCLES in REQ+WAIT.
//   clk, reset             clock, synchronous active-high reset
//   mem_read_m/write_m     load/store present in MEM
//   funct3_m, addr_m       width code and byte address
//   store_data_m           store source value
//   load_data_m            extended load result, nonzero only in DONE
//   lsu_stall              pipeline hold request (combinational)
//   access_err_m           one-cycle misaligned/illegal/timeout pulse
//   bus_*                  registered request side, bus_gnt/rvalid/rdata response
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read_m,
    input  logic             mem_write_m,
    input  logic [2:0]       funct3_m,
    input  logic [BUS_W-1:0] addr_m,
    input  logic [BUS_W-1:0] store_data_m,
    output logic [BUS_W-1:0] load_data_m,
    output logic             lsu_stall,
    output logic             access_err_m,
    output logic             bus_req,
    output logic             bus_we,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_wdata,
    output logic [3:0]       bus_wmask,
    input  logic             bus_gnt,
    input  logic             bus_rvalid,
    input  logic [BUS_W-1:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] tmoCnt;
    logic [BUS_W-1:0] capData;

    logic             opValid;
    logic             alignErr;
    logic [3:0]       alignMask;
    logic [BUS_W-1:0] alignWdata;
    logic [BUS_W-1:0] alignLoad;
    logic             inFlight;
    logic             rdAccept;
    logic             finish;
    logic             timeout;

    assign opValid = mem_read_m | mem_write_m;

    // The EX/MEM register is frozen while we stall, so the live funct3/addr
    // are still valid when read data comes back and can drive extraction.
    lsu_align uAlign (
        .isLoad    (mem_read_m),
        .isStore   (mem_write_m),
        .funct3    (funct3_m),
        .offset    (addr_m[1:0]),
        .storeData (store_data_m),
        .rdata     (bus_rdata),
        .illegal   (alignErr),
        .wmask     (alignMask),
        .wdata     (alignWdata),
        .loadData  (alignLoad)
    );

    assign inFlight = (state == REQ) || (state == WAIT);
    // bus_we is still the latched op kind while in REQ; it reads 0 in WAIT.
    assign rdAccept = bus_rvalid && !bus_we &&
                      (((state == REQ) && bus_gnt) || (state == WAIT));
    assign finish   = ((state == REQ) && bus_gnt && (bus_we || bus_rvalid)) ||
                      ((state == WAIT) && bus_rvalid);
    // A completion landing on the last budgeted cycle wins over the timeout.
    assign timeout  = inFlight && (tmoCnt == CNT_LAST) && !finish;

    assign lsu_stall    = ((state == IDLE) && opValid && !alignErr) || inFlight;
    assign access_err_m = ((state == IDLE) && opValid && alignErr) || timeout;
    assign load_data_m  = (state == DONE) ? capData : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmoCnt    <= '0;
            capData   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (opValid && !alignErr) begin
                        state     <= REQ;
                        tmoCnt    <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write_m;
                        bus_addr  <= {addr_m[BUS_W-1:2], 2'b00};
                        bus_wdata <= alignWdata;
                        bus_wmask <= alignMask;
                    end
                end
                REQ: begin
                    tmoCnt <= tmoCnt + 1'b1;
                    if (bus_gnt || timeout) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_wmask <= 4'b0000;
                    end
                    if (timeout) begin
                        capData <= '0;
                        state   <= DONE;
                    end else if (bus_gnt) begin
                        if (rdAccept)
                            capData <= alignLoad;
                        state <= (bus_we || bus_rvalid) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    tmoCnt <= tmoCnt + 1'b1;
                    if (rdAccept) begin
                        capData <= alignLoad;
                        state   <= DONE;
                    end else if (timeout) begin
                        capData <= '0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_m, mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m, store_data_m;
    logic [31:0] load_data_m;
    logic        lsu_stall, access_err_m;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .addr_m       (addr_m),
        .store_data_m (store_data_m),
        .load_data_m  (load_data_m),
        .lsu_stall    (lsu_stall),
        .access_err_m (access_err_m),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wmask    (bus_wmask),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic        err;
        logic        chkLd;
        logic [31:0] ld;
        int          stall;
    } retire_t;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic        chkWd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } busExp_t;

    retire_t retQ[$];
    busExp_t busQ[$];

    // Monitor: checks every bus handshake and every op retirement
    int   stallCnt = 0;
    logic errAcc   = 1'b0;

    always @(negedge clk) begin
        retire_t r;
        busExp_t b;
        if (reset) begin
            stallCnt = 0;
            errAcc   = 1'b0;
        end else begin
            if (access_err_m) errAcc = 1'b1;
            if (lsu_stall) stallCnt++;
            if (bus_req && bus_gnt) begin
                if (busQ.size() == 0) begin
                    nVec++;
                    nBad++;
                    $display("FAIL unexpected bus handshake: addr 0x%08h we %0d, want none", bus_addr, bus_we);
                end else begin
                    b = busQ.pop_front();
                    chk($sformatf("v%0d bus_we", b.id), 32'(bus_we), 32'(b.we));
                    chk($sformatf("v%0d bus_addr", b.id), bus_addr, b.addr);
                    chk($sformatf("v%0d bus_wmask", b.id), 32'(bus_wmask), 32'(b.wmask));
                    if (b.chkWd) chk($sformatf("v%0d bus_wdata", b.id), bus_wdata, b.wdata);
                end
            end
            if ((mem_read_m || mem_write_m) && !lsu_stall) begin
                if (retQ.size() == 0) begin
                    nVec++;
                    nBad++;
                    $display("FAIL unexpected retire: err %0d stalls %0d, want none", errAcc, stallCnt);
                end else begin
                    r = retQ.pop_front();
                    chk($sformatf("v%0d access_err", r.id), 32'(errAcc), 32'(r.err));
                    chk($sformatf("v%0d stall cycles", r.id), 32'(stallCnt), 32'(r.stall));
                    chk($sformatf("v%0d bus_req at retire", r.id), 32'(bus_req), 32'd0);
                    if (r.chkLd) chk($sformatf("v%0d load_data", r.id), load_data_m, r.ld);
                end
                stallCnt = 0;
                errAcc   = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one op starting now (posedge+1) and returns at posedge+1 of the
    // cycle after the op retires, with the op still on the inputs; the caller
    // immediately issues the next op or goes idle. gntDly < 0 = never grant.
    task automatic doOp(input int id, input logic ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic legal,
                        input int gntDly, input int rvDly, input logic [31:0] rdata,
                        input logic [31:0] expAddr, input logic [3:0] expMask,
                        input logic [31:0] expWd, input logic [31:0] expLd, input int expStall);
        retire_t r;
        busExp_t b;
        r.id = id; r.err = !legal || (gntDly < 0); r.chkLd = ld; r.ld = expLd; r.stall = expStall;
        retQ.push_back(r);
        if (legal && gntDly >= 0) begin
            b.id = id; b.we = !ld; b.addr = expAddr; b.chkWd = !ld; b.wdata = expWd; b.wmask = expMask;
            busQ.push_back(b);
        end
        mem_read_m   = ld;
        mem_write_m  = !ld;
        funct3_m     = f3;
        addr_m       = addr;
        store_data_m = sd;
        @(posedge clk);
        #1;
        if (!legal) return;
        if (gntDly < 0) begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
            end
            // DONE after timeout: a late response must be ignored
            bus_rvalid = 1'b1;
            bus_rdata  = 32'h1111_1111;
            @(posedge clk);
            #1;
            bus_rvalid = 1'b0;
            return;
        end
        for (int i = 0; i < gntDly; i++) begin
            @(posedge clk);
            #1;
        end
        bus_gnt    = 1'b1;
        bus_rvalid = ld && (rvDly == 0);
        bus_rdata  = rdata;
        @(posedge clk);
        #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (ld && rvDly > 0) begin
            for (int i = 1; i < rvDly; i++) begin
                @(posedge clk);
                #1;
            end
            bus_rvalid = 1'b1;
            @(posedge clk);
            #1;
            bus_rvalid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        busExp_t b;
        reset = 1'b1;
        mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b000;
        addr_m = '0; store_data_m = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset ctrl outputs", 32'({bus_req, bus_we, lsu_stall, access_err_m, bus_wmask}), 32'd0);
        chk("reset bus_addr", bus_addr, 32'd0);
        chk("reset bus_wdata", bus_wdata, 32'd0);
        chk("reset load_data", load_data_m, 32'd0);
        reset = 1'b0;
        idle(1);

        //   id ld  f3     addr       sd          ok gnt rv rdata         busAddr    mask     wdata          load         stall
        doOp(1, 0, F3_B,  32'h103, 32'h0000_00AB, 1, 0, 0, 32'h0,         32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0,         2); idle(1);
        doOp(2, 1, F3_B,  32'h102, 32'h0,         1, 0, 3, 32'h0080_0000, 32'h100, 4'b0000, 32'h0,         32'hFFFF_FF80, 5); idle(1);
        doOp(3, 1, F3_BU, 32'h102, 32'h0,         1, 0, 3, 32'h0080_0000, 32'h100, 4'b0000, 32'h0,         32'h0000_0080, 5); idle(1);
        doOp(4, 1, F3_W,  32'h106, 32'h0,         0, 0, 0, 32'h0,         32'h0,   4'b0000, 32'h0,         32'h0,         0); idle(1);
        doOp(5, 0, F3_H,  32'h105, 32'h1234,      0, 0, 0, 32'h0,         32'h0,   4'b0000, 32'h0,         32'h0,         0); idle(1);
        doOp(6, 1, F3_W,  32'h300, 32'h0,         1, -1, 0, 32'h0,        32'h0,   4'b0000, 32'h0,         32'h0,         9); idle(2);

        // reset while a load waits in WAIT; the subsequent rvalid is ignored
        b.id = 7; b.we = 1'b0; b.addr = 32'h104; b.chkWd = 1'b0; b.wdata = '0; b.wmask = 4'b0000;
        busQ.push_back(b);
        mem_read_m = 1'b1; funct3_m = F3_W; addr_m = 32'h104;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mem_read_m = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFE_BABE;
        chk("v7 ctrl after reset", 32'({bus_req, bus_we, lsu_stall, access_err_m, bus_wmask}), 32'd0);
        chk("v7 bus_addr after reset", bus_addr, 32'd0);
        chk("v7 bus_wdata after reset", bus_wdata, 32'd0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        chk("v7 ctrl after late rvalid", 32'({bus_req, lsu_stall, access_err_m}), 32'd0);
        chk("v7 load_data after late rvalid", load_data_m, 32'd0);
        idle(1);

        // back-to-back: each op is issued once, next op in the cycle after DONE
        doOp(8,  0, F3_W,  32'h200, 32'h1234_5678, 1, 0, 0, 32'h0,         32'h200, 4'b1111, 32'h1234_5678, 32'h0,         2);
        doOp(9,  1, F3_HU, 32'h202, 32'h0,         1, 0, 1, 32'hBEEF_0000, 32'h200, 4'b0000, 32'h0,         32'h0000_BEEF, 3); idle(1);
        doOp(10, 0, F3_H,  32'h102, 32'h0000_CAFE, 1, 2, 0, 32'h0,         32'h100, 4'b1100, 32'hCAFE_CAFE, 32'h0,         4); idle(1);
        doOp(11, 1, F3_H,  32'h100, 32'h0,         1, 0, 0, 32'h0000_8001, 32'h100, 4'b0000, 32'h0,         32'hFFFF_8001, 2); idle(1);
        doOp(12, 1, 3'b011, 32'h0,  32'h0,         0, 0, 0, 32'h0,         32'h0,   4'b0000, 32'h0,         32'h0,         0); idle(1);
        doOp(13, 0, F3_BU, 32'h0,   32'h0,         0, 0, 0, 32'h0,         32'h0,   4'b0000, 32'h0,         32'h0,         0); idle(1);
        doOp(14, 1, F3_W,  32'h104, 32'h0,         1, 1, 0, 32'hDEAD_BEEF, 32'h104, 4'b0000, 32'h0,         32'hDEAD_BEEF, 3);
        doOp(15, 0, F3_B,  32'h101, 32'h0000_005A, 1, 0, 0, 32'h0,         32'h100, 4'b0010, 32'h5A5A_5A5A, 32'h0,         2);
        doOp(16, 1, F3_B,  32'h101, 32'h0,         1, 0, 2, 32'h0000_7F00, 32'h100, 4'b0000, 32'h0,         32'h0000_007F, 4); idle(3);

        chk("retire queue drained", 32'(retQ.size()), 32'd0);
        chk("bus queue drained", 32'(busQ.size()), 32'd0);
        chk("idle stall", 32'(lsu_stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the five-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and a handshaked data-memory bus, replacing the fixed full-word write mask with a real one. It generates RV32I byte/half/word masks, sign- or zero-extends loads, and detects misaligned accesses. It also holds the pipeline through a stall output while a multi-cycle bus transaction is outstanding, and times out hung accesses.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum number of cycles spent in REQ+WAIT before the access is abandoned.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read_m`  in  1  load present in MEM stage.
- `mem_write_m`  in  1  store present in MEM stage (never both set).
- `funct3_m`  in  3  RV32I load/store width code.
- `addr_m`  in  32  byte address (ALU result).
- `store_data_m`  in  32  rs2 value, unaligned in the low bits.
- `load_data_m`  out  32  extended load result; valid in DONE only.
- `lsu_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- `access_err_m`  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
- `bus_req`  out  1  request valid; held until `bus_gnt`.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address (`addr_m[31:2]`, 2'b00).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wmask`  out  4  byte enables; 0 for reads.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  read data valid this cycle.
- `bus_rdata`  in  32  read word.

## Operation
- Four states: IDLE, REQ, WAIT, DONE. Reset forces IDLE. All outputs are 0 after reset.
- IDLE, no op: stall 0, no bus activity.
- IDLE, op present and legal: go to REQ; `lsu_stall`=1.
- IDLE, op present and illegal: `access_err_m`=1 for that cycle, `lsu_stall`=0, `load_data_m`=0, no bus access, stay in IDLE. Illegal means:
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠0;
  - funct3 not in {000,001,010,100,101} for loads;
  - funct3 not in {000,001,010} for stores.
- REQ: `bus_req`=1, with address, data, mask and we stable. On `bus_gnt`:
  - store goes to DONE;
  - load with `bus_rvalid` in the same cycle captures data and goes to DONE;
  - otherwise load goes to WAIT.
- WAIT: on `bus_rvalid`, capture `bus_rdata` and go to DONE.
- DONE: `lsu_stall`=0 and `load_data_m` is driven from the capture register, so the pipeline advances at this edge. Next state is always IDLE; the same op is never reissued.
- Timeout: a counter clears on IDLE→REQ and increments in REQ and WAIT. When it reaches `TIMEOUT_CYCLES`-1:
  - pulse `access_err_m`;
  - `load_data_m`=0;
  - drop `bus_req`;
  - go to DONE.
  - A late `bus_rvalid` is then ignored.
- Store mask and data:
  - SB: mask `4'b0001<<addr[1:0]`, data `{4{sd[7:0]}}`.
  - SH: mask `4'b0011<<{addr[1],1'b0}`, data `{2{sd[15:0]}}`.
  - SW: mask 1111.
- Load extraction: select the byte/half by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `lsu_stall` is combinational from state and the op inputs, so an op arriving in IDLE stalls in the same cycle.

## Timing
- Minimum access is 3 cycles: IDLE (stall), REQ with gnt (stall), DONE (no stall). That is 2 stall cycles.
- Each additional cycle of gnt or rvalid latency adds one stall cycle.
- `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_wmask` are registered and change only on IDLE→REQ or on leaving REQ.
- The capture register loads only on an accepted `bus_rvalid`. It is cleared by reset and by timeout.
- Reset asserted mid-transaction: IDLE next cycle, `bus_req` low next cycle, no error pulse.
- An op arriving in the cycle immediately after DONE is treated as a new access.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the state enum `lsu_state_t`;
  - the bus width constant.
- Sub-module `lsu_align` is purely combinational. It produces the misalign/illegal flag, `wmask`, `wdata` and load extraction. It is instantiated once; the FSM, counter and registers stay in the top.

## Test plan
- SB addr 0x103, sd 0x000000AB, gnt on first REQ cycle -> wmask 1000, wdata 0xABABABAB, bus_addr 0x100, stall 2 cycles.
- LB addr 0x102, rdata 0x00800000, rvalid 3 cycles after gnt -> load_data 0xFFFFFF80 in DONE; LBU same -> 0x00000080; stall 5 cycles.
- LW addr 0x106 -> access_err pulse, no bus_req, stall 0, load_data 0; SH addr 0x105 -> same.
- LW, gnt never asserted, TIMEOUT_CYCLES=8 -> access_err at the 8th REQ/WAIT cycle, bus_req low next cycle, DONE, load_data 0.
- Reset during WAIT, then rvalid -> IDLE, rvalid ignored, all outputs 0.
- Back-to-back SW 0x200 then LHU 0x202 (rdata 0xBEEF0000) -> two separate transactions, load_data 0x0000BEEF, no op reissued.
